// File: rtl/adapter_dl_stream.sv
// Downlink IQ adapter: captures packed multi-sample I/Q buses, serialises them into {Q,I} words
// through a FIFO and paces them out to the DUC. Define ADAPTER_DL_STATS_EN for drop/underrun counters.
module adapter_dl_stream #(
    parameter int SAMPLE_W       = 16,
    parameter int SPW            = 2,
    parameter int CAPTURE_PERIOD = 16,
    parameter int CAPTURE_PHASE  = 13,
    parameter int OUT_PERIOD     = 8,
    parameter int FIFO_AW        = 8,
    parameter int PREFILL        = 32
) (
    input  logic                    clk_1,
    input  logic                    rst_n,
    input  logic                    iq_rx_data_valid,
    input  logic [SAMPLE_W*SPW-1:0] iq_rx_i,
    input  logic [SAMPLE_W*SPW-1:0] iq_rx_q,
    output logic [2*SAMPLE_W-1:0]   out_data,
    output logic                    out_valid,
    output logic [FIFO_AW:0]        fifo_level,
    output logic                    overflow,
    output logic                    underflow
`ifdef ADAPTER_DL_STATS_EN
    ,
    output logic [15:0]             drop_count,
    output logic [15:0]             underrun_count
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;
    localparam int PH_W  = (CAPTURE_PERIOD > 1) ? $clog2(CAPTURE_PERIOD) : 1;
    localparam int SL_W  = (OUT_PERIOD > 1) ? $clog2(OUT_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CAPTURE_PERIOD - 1);
    localparam logic [PH_W-1:0] PH_CAP   = PH_W'(CAPTURE_PHASE);
    localparam logic [SL_W-1:0] SL_LAST  = SL_W'(OUT_PERIOD - 1);
    localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]   LVL_PRE  = LW'(PREFILL);

    typedef enum logic {C_IDLE, C_ARMED} cap_st_t;
    typedef enum logic {R_PREFILL, R_STREAM} rd_st_t;

    cap_st_t cap_st, cap_nx;
    rd_st_t  rd_st, rd_nx;

    logic [PH_W-1:0]               phase;
    logic [SL_W-1:0]               slot;
    logic [SPW-1:0][SAMPLE_W-1:0]  sh_i, sh_q;
    logic [SPW-1:0]                ser_vld;
    logic [2*SAMPLE_W-1:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]            wr_ptr, rd_ptr;
    logic cap_fire, rd_slot, fifo_empty, fifo_full, do_wr, do_rd, drop, underrun;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            cap_st <= C_IDLE;
            rd_st  <= R_PREFILL;
        end else begin
            cap_st <= cap_nx;
            rd_st  <= rd_nx;
        end
    end

    always_comb begin
        cap_nx = cap_st;
        if (cap_st == C_IDLE && iq_rx_data_valid)
            cap_nx = C_ARMED;
        rd_nx = rd_st;
        case (rd_st)
            R_PREFILL: if (fifo_level >= LVL_PRE) rd_nx = R_STREAM;
            R_STREAM:  if (underrun) rd_nx = R_PREFILL;
            default:   rd_nx = R_PREFILL;
        endcase
    end

    // A write at full is only accepted when the same edge pops; an empty slot never reads through.
    always_comb begin
        cap_fire   = (cap_st == C_ARMED) && (phase == PH_CAP);
        rd_slot    = (rd_st == R_STREAM) && (slot == SL_LAST);
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == LVL_FULL);
        do_rd      = rd_slot && !fifo_empty;
        underrun   = rd_slot && fifo_empty;
        do_wr      = ser_vld[0] && (!fifo_full || do_rd);
        drop       = ser_vld[0] && fifo_full && !do_rd;
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            slot  <= '0;
        end else begin
            if (cap_st == C_ARMED)
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (rd_st == R_STREAM)
                slot <= (slot == SL_LAST) ? '0 : slot + 1'b1;
            else
                slot <= '0;
        end
    end

    // Lane 0 always sits at the bottom; shifting down by one sample presents lanes in order.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            ser_vld <= '0;
            sh_i    <= '0;
            sh_q    <= '0;
        end else if (cap_fire) begin
            ser_vld <= '1;
            sh_i    <= iq_rx_i;
            sh_q    <= iq_rx_q;
        end else begin
            ser_vld <= ser_vld >> 1;
            sh_i    <= sh_i >> SAMPLE_W;
            sh_q    <= sh_q >> SAMPLE_W;
        end
    end

    always_ff @(posedge clk_1) begin
        if (do_wr)
            mem[wr_ptr] <= {sh_q[0], sh_i[0]};
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
            end
            out_valid  <= do_rd;
            fifo_level <= fifo_level + LW'(do_wr) - LW'(do_rd);
            if (drop)
                overflow <= 1'b1;
            if (underrun)
                underflow <= 1'b1;
        end
    end

`ifdef ADAPTER_DL_STATS_EN
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            drop_count     <= '0;
            underrun_count <= '0;
        end else begin
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adapter_dl_stream.sv
// Bench for adapter_dl_stream: three configurations (balanced, overflowing, underflowing) share random
// stimulus and are each compared every cycle against a queue-based timing model.
module tb_adapter_dl_stream;
    logic        clk_1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        iq_rx_data_valid = 1'b0;
    logic [63:0] i_bus = '0;
    logic [63:0] q_bus = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int SW    = (g == 1) ? 12 : 16;
        localparam int NS    = (g == 1) ? 4 : 2;
        localparam int CP    = (g == 2) ? 64 : 16;
        localparam int PH    = (g == 1) ? 5 : 13;
        localparam int OP    = (g == 1) ? 5 : 8;
        localparam int AW    = (g == 0) ? 8 : (g == 1) ? 2 : 4;
        localparam int PRE   = (g == 0) ? 32 : (g == 1) ? 4 : 2;
        localparam int DEPTH = 1 << AW;
        localparam int WW    = 2 * SW;

        logic [WW-1:0] out_data;
        logic          out_valid;
        logic [AW:0]   fifo_level;
        logic          overflow, underflow;
`ifdef ADAPTER_DL_STATS_EN
        logic [15:0]   drop_count, underrun_count;
`endif

        adapter_dl_stream #(
            .SAMPLE_W(SW), .SPW(NS), .CAPTURE_PERIOD(CP), .CAPTURE_PHASE(PH),
            .OUT_PERIOD(OP), .FIFO_AW(AW), .PREFILL(PRE)
        ) u_dut (
            .clk_1            (clk_1),
            .rst_n            (rst_n),
            .iq_rx_data_valid (iq_rx_data_valid),
            .iq_rx_i          (i_bus[SW*NS-1:0]),
            .iq_rx_q          (q_bus[SW*NS-1:0]),
            .out_data         (out_data),
            .out_valid        (out_valid),
            .fifo_level       (fifo_level),
            .overflow         (overflow),
            .underflow        (underflow)
`ifdef ADAPTER_DL_STATS_EN
            ,
            .drop_count       (drop_count),
            .underrun_count   (underrun_count)
`endif
        );

        // Model: words waiting to be serialised, FIFO contents, and elapsed-time counters.
        logic [WW-1:0] mq[$];
        logic [WW-1:0] pend[$];
        logic [WW-1:0] m_data = '0;
        bit armed = 0, streaming = 0, m_vld = 0, m_ovf = 0, m_unf = 0;
        int age = 0, since_stream = 0, m_drops = 0, m_unders = 0;

        always @(negedge rst_n) begin
            mq.delete();
            pend.delete();
            m_data = '0;
            armed = 0; streaming = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
            age = 0; since_stream = 0; m_drops = 0; m_unders = 0;
        end

        always @(posedge clk_1) begin : model
            int lvl_pre;
            bit wr, slot_hit;
            logic [WW-1:0] w;
            if (rst_n) begin
                lvl_pre = mq.size();
                wr = (pend.size() != 0);
                w = '0;
                if (wr) w = pend.pop_front();
                slot_hit = 0;
                if (streaming) begin
                    since_stream++;
                    slot_hit = (since_stream % OP) == 0;
                end
                m_vld = 0;
                if (slot_hit) begin
                    if (lvl_pre == 0) begin
                        m_unf = 1;
                        streaming = 0;
                        if (m_unders < 65535) m_unders++;
                    end else begin
                        m_data = mq.pop_front();
                        m_vld = 1;
                    end
                end else if (!streaming && lvl_pre >= PRE) begin
                    streaming = 1;
                    since_stream = 0;
                end
                if (wr) begin
                    if (mq.size() < DEPTH) mq.push_back(w);
                    else begin
                        m_ovf = 1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
                if (armed) begin
                    age++;
                    if ((age - 1) % CP == PH)
                        for (int k = 0; k < NS; k++)
                            pend.push_back({q_bus[k*SW +: SW], i_bus[k*SW +: SW]});
                end else if (iq_rx_data_valid) begin
                    armed = 1;
                    age = 0;
                end
            end
            #1;
            if (rst_n) begin
                chk($sformatf("c%0d.level", g), 64'(fifo_level), 64'(mq.size()));
                chk($sformatf("c%0d.out_valid", g), 64'(out_valid), 64'(m_vld));
                chk($sformatf("c%0d.out_data", g), 64'(out_data), 64'(m_data));
                chk($sformatf("c%0d.overflow", g), 64'(overflow), 64'(m_ovf));
                chk($sformatf("c%0d.underflow", g), 64'(underflow), 64'(m_unf));
`ifdef ADAPTER_DL_STATS_EN
                chk($sformatf("c%0d.drop_count", g), 64'(drop_count), 64'(m_drops));
                chk($sformatf("c%0d.underrun_count", g), 64'(underrun_count), 64'(m_unders));
`endif
            end
        end
    end

    task automatic rand_bus();
        i_bus = {$urandom, $urandom};
        q_bus = {$urandom, $urandom};
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk_1);
        chk("rst.c0.out_valid", 64'(g_cfg[0].out_valid), 64'd0);
        chk("rst.c0.out_data", 64'(g_cfg[0].out_data), 64'd0);
        chk("rst.c0.level", 64'(g_cfg[0].fifo_level), 64'd0);
        chk("rst.c1.overflow", 64'(g_cfg[1].overflow), 64'd0);
        chk("rst.c2.underflow", 64'(g_cfg[2].underflow), 64'd0);
        #2 rst_n = 1'b1;

        // Constant bus, single valid pulse at E0: capture at E14, words at E15/E16.
        i_bus = 64'h0000_0000_BBBB_AAAA;
        q_bus = 64'h0000_0000_DDDD_CCCC;
        repeat (2) @(negedge clk_1);
        iq_rx_data_valid = 1'b1;
        @(negedge clk_1);
        iq_rx_data_valid = 1'b0;
        repeat (15) @(negedge clk_1);
        chk("dir.c0.level_e15", 64'(g_cfg[0].fifo_level), 64'd1);
        @(negedge clk_1);
        chk("dir.c0.level_e16", 64'(g_cfg[0].fifo_level), 64'd2);

        seen = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk_1);
            rand_bus();
            iq_rx_data_valid = 1'($urandom_range(0, 1));
            if (g_cfg[0].out_valid) begin
                seen = 1;
                chk("dir.c0.first_word", 64'(g_cfg[0].out_data), 64'hCCCC_AAAA);
            end
        end
        if (!seen) chk("dir.c0.first_out_timeout", 64'd0, 64'd1);

        repeat (1500) begin
            @(negedge clk_1);
            rand_bus();
            iq_rx_data_valid = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset mid-stream, roughly one cycle long.
        @(negedge clk_1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.c0.out_data", 64'(g_cfg[0].out_data), 64'd0);
        chk("arst.c0.level", 64'(g_cfg[0].fifo_level), 64'd0);
        chk("arst.c1.overflow", 64'(g_cfg[1].overflow), 64'd0);
        chk("arst.c1.level", 64'(g_cfg[1].fifo_level), 64'd0);
        chk("arst.c2.underflow", 64'(g_cfg[2].underflow), 64'd0);
        chk("arst.c2.out_valid", 64'(g_cfg[2].out_valid), 64'd0);
        iq_rx_data_valid = 1'b0;
        @(negedge clk_1);
        #2 rst_n = 1'b1;

        repeat (40) begin
            @(negedge clk_1);
            rand_bus();
        end
        chk("post_rst.c0.level", 64'(g_cfg[0].fifo_level), 64'd0);
        chk("post_rst.c1.level", 64'(g_cfg[1].fifo_level), 64'd0);

        iq_rx_data_valid = 1'b1;
        repeat (1200) begin
            @(negedge clk_1);
            rand_bus();
            iq_rx_data_valid = 1'($urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adapter_dl_stream.md
Name: adapter_dl_stream

Overview:
- Parametrised downlink adapter between the UTRA-FDD IQ source and the DUC.
- Arms on the first `iq_rx_data_valid`, then captures the packed multi-sample I/Q buses once per capture period.
- Serialises each capture into per-sample `{Q,I}` words and buffers them in an internal FIFO.
- After a prefill threshold is reached, emits one word every `OUT_PERIOD` cycles, with sticky overflow/underflow reporting. Single clock domain.

Parameters:
- SAMPLE_W, 16, bits per I or Q sample.
- SPW, 2, samples packed per input bus (lane 0 = LSBs).
- CAPTURE_PERIOD, 16, `clk_1` cycles between captures; must be >= SPW.
- CAPTURE_PHASE, 13, phase-counter value at which capture occurs; must be < CAPTURE_PERIOD.
- OUT_PERIOD, 8, `clk_1` cycles between output words; must be >= 1.
- FIFO_AW, 8, FIFO address width; depth = 2^FIFO_AW words.
- PREFILL, 32, FIFO level required before streaming starts; must be <= depth.

Ports:
- clk_1  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- iq_rx_data_valid  in  1  source-valid; the first high sample arms the block.
- iq_rx_i  in  SAMPLE_W*SPW  packed I samples.
- iq_rx_q  in  SAMPLE_W*SPW  packed Q samples.
- out_data  out  2*SAMPLE_W  {Q,I} word to the DUC.
- out_valid  out  1  one-cycle pulse per emitted word.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- underflow  out  1  sticky: an output slot found the FIFO empty.

Behaviour:
- Reset values: all outputs 0; the capture FSM is IDLE; the read FSM is PREFILL; all counters are 0. Reset asserted mid-operation clears everything immediately, including FIFO pointers and the sticky flags.
- Capture FSM, IDLE -> ARMED:
  - Transition happens on the first edge where `iq_rx_data_valid` = 1. The FSM never returns to IDLE except via reset.
  - In ARMED, `phase` counts 0..CAPTURE_PERIOD-1 and wraps to 0.
  - On the edge where `phase` == CAPTURE_PHASE, both buses are registered.
- Serialiser:
  - On the SPW edges following a capture, writes word k = `{q_lane[k], i_lane[k]}`, k = 0..SPW-1 in order, one word per cycle.
  - The lane k slice is bits [k*SAMPLE_W +: SAMPLE_W].
- FIFO write rules:
  - A write attempted while full (level == depth) with no simultaneous read: the word is dropped, `overflow` is set, and the level is unchanged.
  - Simultaneous read and write at full: the write is accepted and the level is unchanged.
- Read FSM:
  - PREFILL -> STREAM when `fifo_level` >= PREFILL. Entering STREAM clears the out-slot counter to 0.
  - In STREAM, each time the slot counter reaches OUT_PERIOD-1 (then wraps to 0), one word is popped. `out_data` is registered from the FIFO head and `out_valid` = 1 for exactly that cycle. `out_data` holds its value between pulses.
  - If the FIFO is empty at a slot: `out_valid` stays 0, `underflow` is set, and the FSM returns to PREFILL.
  - A same-cycle write into an empty FIFO is not read through.
- Latency:
  - Capture edge to first FIFO write: 1 cycle.
  - Pop edge to `out_valid`: registered on the same edge, visible the following cycle.
- Steady-state rate matching requires OUT_PERIOD*SPW == CAPTURE_PERIOD. This is not checked in RTL.
- `fifo_level` reflects the post-edge occupancy.

Optional Feature:
- Macro: ADAPTER_DL_STATS_EN.
- Defined: adds output ports `drop_count[15:0]` and `underrun_count[15:0]`.
  - They increment on each overflow drop and each underflow slot respectively.
  - They saturate at 0xFFFF and reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
1. Defaults; pulse valid at edge E0 with `iq_rx_i` = 0xBBBBAAAA and `iq_rx_q` = 0xDDDDCCCC held -> capture at E14; FIFO receives 0xCCCCAAAA at E15 and 0xDDDDBBBB at E16.
2. Defaults, constant stream -> `fifo_level` reaches 32 after 16 captures. `out_valid` then pulses every 8 cycles, the level stays within 31..33, and `overflow` = `underflow` = 0.
3. FIFO_AW=2, PREFILL=4, OUT_PERIOD=64 -> the 5th word is dropped and `overflow` = 1. With STATS_EN, `drop_count` increments by 1 per dropped word.
4. PREFILL=2, CAPTURE_PERIOD=64, OUT_PERIOD=8 -> after 2 words stream out, the next slot finds the FIFO empty: `underflow` = 1, the read FSM is back in PREFILL, and no `out_valid` occurs until the level reaches 2 again.
5. Assert `rst_n` low mid-stream for 1 cycle -> all outputs return to 0 asynchronously; after release, no capture occurs until a new `iq_rx_data_valid`.
6. SAMPLE_W=12, SPW=4, CAPTURE_PERIOD=16, OUT_PERIOD=4 -> each capture yields 4 words in lane order 0..3, each 24 bits `{Q,I}`.
